// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package mod_counter_pkg;

    // Encoding of the select input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Largest value the counter may hold (MODULUS-1), masked to WIDTH bits.
    function automatic longint unsigned range_end(input int unsigned width,
                                                  input longint unsigned modulus);
        return (modulus - 64'd1) & ((64'd1 << width) - 64'd1);
    endfunction

    // True when WIDTH and MODULUS describe a buildable counter.
    function automatic bit legal_params(input int unsigned width,
                                        input longint unsigned modulus);
        if (width < 2 || width > 32) return 1'b0;
        if (modulus < 64'd2 || modulus > (64'd1 << width)) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and terminal-count logic for mod_counter.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             select,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(range_end(WIDTH, MODULUS));

    logic at_end;

    // Priority clr > load > en > hold; range ends either wrap or hold.
    always_comb begin
        at_end     = (select == DIR_UP) ? (count == MAX) : (count == '0);
        tc         = en & ~clr & ~load & at_end;
        next_count = count;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the range.
            next_count = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (select == DIR_UP) begin
                if (at_end) next_count = (SATURATE != 0) ? MAX : '0;
                else        next_count = count + WIDTH'(1);
            end else begin
                if (at_end) next_count = (SATURATE != 0) ? '0 : MAX;
                else        next_count = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, optional saturation and sticky
// overflow flag. Holds only the count and ovf registers.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             select,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Reject parameter sets the counter cannot represent.
    if (!legal_params(WIDTH, MODULUS)) begin : g_bad_params
        $error("mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    logic [WIDTH-1:0] next_count;
    logic             tc_raw;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .select     (select),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count),
        .tc         (tc_raw)
    );

    // Terminal count is suppressed while reset is asserted.
    assign tc = tc_raw & rst;

    // Count register: cleared asynchronously, otherwise takes the next value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= next_count;
    end

    // Sticky overflow: a terminal-count edge wins over a clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (tc)      ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: a wrapping and a saturating instance (WIDTH=4,
// MODULUS=10) share stimulus and are compared against an arithmetic model.
module tb_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, select = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    int n_vec = 0;
    int n_err = 0;

    // Model state: index 0 = wrapping instance, index 1 = saturating instance.
    int m_cnt[2];
    bit m_ovf[2];

    mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .select(select), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(count_w), .tc(tc_w), .ovf(ovf_w)
    );

    mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .select(select), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s), .ovf(ovf_s)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model: expected terminal count for the current inputs.
    function automatic bit model_tc(input int s);
        if (!rst || !en || clr || load) return 1'b0;
        if (select == 1'b0) return m_cnt[s] == M - 1;
        return m_cnt[s] == 0;
    endfunction

    // Reference model: expected count after the next edge.
    function automatic int model_next(input int s);
        int c;
        c = m_cnt[s];
        if (!rst) return 0;
        if (clr) return 0;
        if (load) return (int'(load_val) < M) ? int'(load_val) : M - 1;
        if (!en) return c;
        if (select == 1'b0) return (s == 1) ? ((c + 1 > M - 1) ? M - 1 : c + 1) : (c + 1) % M;
        return (s == 1) ? ((c - 1 < 0) ? 0 : c - 1) : (c - 1 + M) % M;
    endfunction

    // Driver: one clock edge, model advanced alongside; returns at posedge+1.
    task automatic tick();
        int n[2];
        bit t[2];
        for (int s = 0; s < 2; s++) begin
            t[s] = model_tc(s);
            n[s] = model_next(s);
        end
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = n[s];
            if (!rst)         m_ovf[s] = 1'b0;
            else if (t[s])    m_ovf[s] = 1'b1;
            else if (ovf_clr) m_ovf[s] = 1'b0;
        end
        #1;
    endtask

    // Driver: quiet inputs, pulse reset across one edge, release off-edge.
    task automatic do_reset();
        en = 0; select = 0; clr = 0; load = 0; ovf_clr = 0; load_val = '0;
        rst = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        en = 1; select = 1;   // down at 0 would be terminal count if not in reset
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({count_w, ovf_w, tc_w, count_s, ovf_s, tc_s} !== {4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got cw=%0d ow=%b tw=%b cs=%0d os=%b ts=%b, required all 0",
                     count_w, ovf_w, tc_w, count_s, ovf_s, tc_s);
        end
        en = 0; select = 0;
        rst = 1;
        tick();
        n_vec++;
        if ({count_w, count_s} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_release_hold: got %0d/%0d, required 0/0", count_w, count_s);
        end
    endtask

    task automatic test_up_wrap();
        do_reset();
        select = 0; en = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_vec++;
            if (tc_w !== ((i % 10) == 9)) begin
                n_err++;
                $display("FAIL up_wrap_tc[%0d]: got %b, required %b", i, tc_w, (i % 10) == 9);
            end
            tick();
            n_vec++;
            if (count_w !== 4'((i + 1) % 10) || ovf_w !== (i >= 9)) begin
                n_err++;
                $display("FAIL up_wrap_count[%0d]: got count=%0d ovf=%b, required count=%0d ovf=%b",
                         i, count_w, ovf_w, (i + 1) % 10, i >= 9);
            end
            n_vec++;
            if ({count_s, ovf_s} !== {4'(m_cnt[1]), m_ovf[1]}) begin
                n_err++;
                $display("FAIL up_sat_count[%0d]: got count=%0d ovf=%b, required count=%0d ovf=%b",
                         i, count_s, ovf_s, m_cnt[1], m_ovf[1]);
            end
        end
    endtask

    task automatic test_down_sat();
        do_reset();
        load = 1; load_val = 4'd2;
        tick();
        n_vec++;
        if ({count_w, count_s} !== {4'd2, 4'd2}) begin
            n_err++;
            $display("FAIL down_load: got %0d/%0d, required 2/2", count_w, count_s);
        end
        load = 0; select = 1; en = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (tc_s !== (i >= 2) || tc_w !== model_tc(0)) begin
                n_err++;
                $display("FAIL down_tc[%0d]: got ts=%b tw=%b, required ts=%b tw=%b",
                         i, tc_s, tc_w, i >= 2, model_tc(0));
            end
            tick();
            n_vec++;
            if (count_s !== 4'((i < 2) ? 1 - i : 0) || count_w !== 4'(m_cnt[0])) begin
                n_err++;
                $display("FAIL down_count[%0d]: got cs=%0d cw=%0d, required cs=%0d cw=%0d",
                         i, count_s, count_w, (i < 2) ? 1 - i : 0, m_cnt[0]);
            end
        end
        n_vec++;
        if (ovf_s !== 1'b1 || ovf_w !== 1'b1) begin
            n_err++;
            $display("FAIL down_ovf: got os=%b ow=%b, required 1/1", ovf_s, ovf_w);
        end
    endtask

    task automatic test_load_clamp();
        do_reset();
        load = 1; load_val = 4'hE;
        tick();
        n_vec++;
        if ({count_w, count_s} !== {4'd9, 4'd9}) begin
            n_err++;
            $display("FAIL load_clamp: got %0d/%0d, required 9/9", count_w, count_s);
        end
        load_val = 4'd5;
        tick();
        n_vec++;
        if ({count_w, count_s} !== {4'd5, 4'd5}) begin
            n_err++;
            $display("FAIL load_inrange: got %0d/%0d, required 5/5", count_w, count_s);
        end
        load = 0;
    endtask

    task automatic test_priority();
        do_reset();
        load = 1; load_val = 4'd7;
        tick();
        clr = 1; load = 1; en = 1; load_val = 4'd5;
        #1;
        n_vec++;
        if (tc_w !== 1'b0) begin
            n_err++;
            $display("FAIL prio_tc: got %b, required 0", tc_w);
        end
        tick();
        n_vec++;
        if ({count_w, count_s} !== 8'h00) begin
            n_err++;
            $display("FAIL prio_clr: got %0d/%0d, required 0/0", count_w, count_s);
        end
        clr = 0; load = 1; en = 1; load_val = 4'd3;
        tick();
        n_vec++;
        if ({count_w, count_s} !== {4'd3, 4'd3}) begin
            n_err++;
            $display("FAIL prio_load: got %0d/%0d, required 3/3", count_w, count_s);
        end
        load = 0; en = 0;
    endtask

    task automatic test_ovf_race();
        do_reset();
        load = 1; load_val = 4'd9;
        tick();
        load = 0; en = 1; select = 0; ovf_clr = 1;
        #1;
        n_vec++;
        if (tc_w !== 1'b1) begin
            n_err++;
            $display("FAIL race_tc: got %b, required 1", tc_w);
        end
        tick();
        n_vec++;
        if (ovf_w !== 1'b1 || count_w !== 4'd0) begin
            n_err++;
            $display("FAIL race_set_wins: got ovf=%b count=%0d, required ovf=1 count=0", ovf_w, count_w);
        end
        tick();
        n_vec++;
        if (ovf_w !== 1'b0 || count_w !== 4'd1) begin
            n_err++;
            $display("FAIL race_clear: got ovf=%b count=%0d, required ovf=0 count=1", ovf_w, count_w);
        end
        n_vec++;
        if ({count_s, ovf_s} !== {4'(m_cnt[1]), m_ovf[1]}) begin
            n_err++;
            $display("FAIL race_sat: got count=%0d ovf=%b, required count=%0d ovf=%b",
                     count_s, ovf_s, m_cnt[1], m_ovf[1]);
        end
        en = 0; ovf_clr = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1; load_val = 4'd9;
        tick();
        load = 0; en = 1;
        tick();                      // wraps: ovf set
        load = 1; load_val = 4'd6; en = 0;
        tick();
        load = 0;
        n_vec++;
        if (count_w !== 4'd6 || ovf_w !== 1'b1) begin
            n_err++;
            $display("FAIL areset_setup: got count=%0d ovf=%b, required 6/1", count_w, ovf_w);
        end
        #2;
        rst = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        #1;
        n_vec++;
        if ({count_w, ovf_w, count_s, ovf_s} !== 10'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got cw=%0d ow=%b cs=%0d os=%b, required 0",
                     count_w, ovf_w, count_s, ovf_s);
        end
        en = 1; select = 1; load = 1; load_val = 4'd4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({count_w, ovf_w, tc_w, count_s, ovf_s, tc_s} !== 12'd0) begin
                n_err++;
                $display("FAIL areset_hold[%0d]: got cw=%0d ow=%b tw=%b cs=%0d os=%b ts=%b, required 0",
                         i, count_w, ovf_w, tc_w, count_s, ovf_s, tc_s);
            end
        end
        rst = 1; en = 0; load = 0; select = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            select   = $urandom_range(0, 1);
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, 15));
            ovf_clr  = ($urandom_range(0, 5) == 0);
            #1;
            n_vec++;
            if (tc_w !== model_tc(0) || tc_s !== model_tc(1)) begin
                n_err++;
                $display("FAIL rand_tc[%0d]: got tw=%b ts=%b, required tw=%b ts=%b",
                         i, tc_w, tc_s, model_tc(0), model_tc(1));
            end
            tick();
            n_vec++;
            if ({count_w, ovf_w, count_s, ovf_s} !== {4'(m_cnt[0]), m_ovf[0], 4'(m_cnt[1]), m_ovf[1]}) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got cw=%0d ow=%b cs=%0d os=%b, required cw=%0d ow=%b cs=%0d os=%b",
                         i, count_w, ovf_w, count_s, ovf_s, m_cnt[0], m_ovf[0], m_cnt[1], m_ovf[1]);
            end
        end
        en = 0; clr = 0; load = 0; ovf_clr = 0;
    endtask

    initial begin
        #2;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_priority();
        test_ovf_race();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
